mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: cycles without ack before a transaction aborts; legal range 1..255.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 inst_ce_i  in  1  fetch request; held stable by the requester until inst_done_o.
REQ-005 inst_addr_i  in  32  fetch word address.
REQ-006 data_ce_i  in  1  load/store request from the MEM stage; held stable until data_done_o.
REQ-007 data_we_i  in  1  1 = store, 0 = load.
REQ-008 data_sel_i  in  4  byte lanes; bit 3 = bits 31:24.
REQ-009 data_addr_i  in  32  data address.
REQ-010 data_wdata_i  in  32  store data, already lane-replicated.
REQ-011 m_ack_i  in  1  memory completion; m_rdata_i valid in the same cycle.
REQ-012 m_rdata_i  in  32  memory read data.
REQ-013 m_ce_o, m_we_o  out  1 each  shared-port chip enable and write enable.
REQ-014 m_sel_o  out  4  shared-port byte select.
REQ-015 m_addr_o, m_wdata_o  out  32 each  shared-port address and write data.
REQ-016 inst_data_o, data_rdata_o  out  32 each  registered read results.
REQ-017 inst_done_o, data_done_o  out  1 each  one-cycle completion pulses.
REQ-018 bus_err_o  out  1  one-cycle pulse, coincident with a done pulse, flagging a timeout.
REQ-019 stall_if_o, stall_mem_o  out  1 each  stall requests to the pipeline controller.

Function
REQ-020 States: IDLE, D_BUSY, I_BUSY; registered encoding.
REQ-021 IDLE: if data_ce_i, latch the data request and go to D_BUSY.
REQ-022 IDLE: else if inst_ce_i, latch the fetch request and go to I_BUSY.
REQ-023 Data has fixed priority over fetch when both requests arrive together.
REQ-024 IDLE: a port whose done pulse is high in the current cycle shall not launch a transaction; this prevents relaunching a completed request.
REQ-025 Busy states: m_ce_o=1; m_addr_o, m_we_o, m_sel_o and m_wdata_o come from the latched request.
REQ-026 Fetch transactions: m_we_o=0, m_sel_o=4'b1111, m_wdata_o=0.
REQ-027 IDLE: m_ce_o=0, m_we_o=0, m_sel_o=0, m_addr_o=0, m_wdata_o=0.
REQ-028 On m_ack_i in a busy state, at the next edge: return to IDLE and pulse the owning port's done for one cycle.
REQ-029 On that completion, the owning port's result register takes m_rdata_i; a store leaves data_rdata_o unchanged.
REQ-030 Minimum latency is 2 cycles from request to done (launch edge plus ack edge, with ack in the first busy cycle).
REQ-031 Wait counter: 8 bits, cleared on entry to a busy state, incremented each busy cycle without ack.
REQ-032 Timeout: when the counter reaches TIMEOUT with no ack, go to IDLE, pulse the owning done and bus_err_o, and load 0 into the result register (loads and fetches only).
REQ-033 If ack and timeout occur in the same cycle, ack wins and bus_err_o stays 0.
REQ-034 stall_mem_o = data_ce_i and not data_done_o; combinational.
REQ-035 stall_if_o = inst_ce_i and not inst_done_o; combinational.
REQ-036 Requests dropped mid-transaction are ignored; the transaction completes normally.

Reset
REQ-037 rst high at an edge forces IDLE and clears the counter, all result registers and all outputs to 0, including mid-transaction.
REQ-038 Any m_ack_i in the reset cycle is discarded.

Structure
REQ-039 State encodings, ChipEnable/WriteEnable constants and bus widths belong in the shared define header used by the pipeline.
REQ-040 The wait counter and timeout compare form one sub-module, bus_watchdog (inputs: clear, enable; output: expired).

Verification
REQ-041 Store only: data_ce_i=1, we=1, sel=4'b0100, addr=0x104, wdata=0x5A5A5A5A, ack in 3rd busy cycle -> bus shows those values for 3 cycles, data_done_o pulses, stall_mem_o low after the pulse.
REQ-042 Simultaneous requests: data load at 0x200 and fetch at 0x400, ack=1 every busy cycle -> data first (rdata=0x11111111), then fetch (inst_data_o=0x22222222); the fetch done follows the data done by 2 cycles.
REQ-043 Timeout with TIMEOUT=4 and ack never asserted -> done and bus_err_o pulse together, data_rdata_o=0, state returns to IDLE.
REQ-044 Reset with rst asserted in the 2nd busy cycle of a fetch -> next cycle all outputs 0, m_ce_o=0; a later ack is ignored.
REQ-045 No relaunch: a data request held high through its done cycle -> exactly one bus transaction occurs.
REQ-046 Ack and timeout together with TIMEOUT=2 and ack in the same cycle -> bus_err_o=0 and rdata = m_rdata_i.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the instruction/data memory bus arbiter.
// Holds the state encodings, the enable constants, the bus widths and the request record.
package mem_bus_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SEL_W  = 4;
    localparam int WAIT_W = 8;

    localparam logic CHIP_ENABLE   = 1'b1;
    localparam logic CHIP_DISABLE  = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    localparam logic [SEL_W-1:0] SEL_ALL = 4'b1111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        D_BUSY = 2'd1,
        I_BUSY = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic              ce;
        logic              we;
        logic [SEL_W-1:0]  sel;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

    // A fetch is always a full-word read with no write data on the bus.
    function automatic bus_req_t fetch_req(input logic [ADDR_W-1:0] addr);
        bus_req_t r;
        r.ce    = CHIP_ENABLE;
        r.we    = WRITE_DISABLE;
        r.sel   = SEL_ALL;
        r.addr  = addr;
        r.wdata = '0;
        return r;
    endfunction

    function automatic bus_req_t data_req(input logic              we,
                                          input logic [SEL_W-1:0]  sel,
                                          input logic [ADDR_W-1:0] addr,
                                          input logic [DATA_W-1:0] wdata);
        bus_req_t r;
        r.ce    = CHIP_ENABLE;
        r.we    = we;
        r.sel   = sel;
        r.addr  = addr;
        r.wdata = wdata;
        return r;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the two requester ports and the shared memory port.
// The master modport is the arbiter's view; slave is the requester/memory side.
interface mem_bus_arbiter_if;
    import mem_bus_arbiter_pkg::*;

    logic              inst_ce_i;
    logic [ADDR_W-1:0] inst_addr_i;
    logic              data_ce_i;
    logic              data_we_i;
    logic [SEL_W-1:0]  data_sel_i;
    logic [ADDR_W-1:0] data_addr_i;
    logic [DATA_W-1:0] data_wdata_i;
    logic              m_ack_i;
    logic [DATA_W-1:0] m_rdata_i;

    logic              m_ce_o;
    logic              m_we_o;
    logic [SEL_W-1:0]  m_sel_o;
    logic [ADDR_W-1:0] m_addr_o;
    logic [DATA_W-1:0] m_wdata_o;
    logic [DATA_W-1:0] inst_data_o;
    logic [DATA_W-1:0] data_rdata_o;
    logic              inst_done_o;
    logic              data_done_o;
    logic              bus_err_o;
    logic              stall_if_o;
    logic              stall_mem_o;

    modport master (
        input  inst_ce_i, inst_addr_i, data_ce_i, data_we_i, data_sel_i,
               data_addr_i, data_wdata_i, m_ack_i, m_rdata_i,
        output m_ce_o, m_we_o, m_sel_o, m_addr_o, m_wdata_o, inst_data_o,
               data_rdata_o, inst_done_o, data_done_o, bus_err_o,
               stall_if_o, stall_mem_o
    );

    modport slave (
        output inst_ce_i, inst_addr_i, data_ce_i, data_we_i, data_sel_i,
               data_addr_i, data_wdata_i, m_ack_i, m_rdata_i,
        input  m_ce_o, m_we_o, m_sel_o, m_addr_o, m_wdata_o, inst_data_o,
               data_rdata_o, inst_done_o, data_done_o, bus_err_o,
               stall_if_o, stall_mem_o
    );

endinterface

// File: rtl/mem_bus_arbiter_bus_watchdog.sv
// Wait counter for the arbiter: counts busy cycles without ack and flags
// expiry once TIMEOUT such cycles have already elapsed.
module bus_watchdog
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(TIMEOUT);

    logic [WAIT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + WAIT_W'(1);
        end
    end

    // Only meaningful while waiting; an ack in the same cycle masks expiry via enable.
    assign expired = enable && (count == LIMIT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between instruction fetch and MEM-stage load/store,
// data first, with a watchdog that aborts transactions that never get an ack.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    mem_bus_arbiter_if.master bus
);

    arb_state_t        state;
    bus_req_t          req_q;
    logic [DATA_W-1:0] inst_data_q;
    logic [DATA_W-1:0] data_rdata_q;
    logic              inst_done_q;
    logic              data_done_q;
    logic              bus_err_q;

    logic launch_data;
    logic launch_inst;
    logic busy;
    logic expired;

    // A port whose done is still high is the request that just finished, so it must not relaunch.
    always_comb begin
        busy        = (state != IDLE);
        launch_data = (state == IDLE) && bus.data_ce_i && !data_done_q;
        launch_inst = (state == IDLE) && !launch_data && bus.inst_ce_i && !inst_done_q;
    end

    bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (launch_data || launch_inst),
        .enable  (busy && !bus.m_ack_i),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            req_q        <= '0;
            inst_data_q  <= '0;
            data_rdata_q <= '0;
            inst_done_q  <= 1'b0;
            data_done_q  <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            inst_done_q <= 1'b0;
            data_done_q <= 1'b0;
            bus_err_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch_data) begin
                        req_q <= data_req(bus.data_we_i, bus.data_sel_i,
                                          bus.data_addr_i, bus.data_wdata_i);
                        state <= D_BUSY;
                    end else if (launch_inst) begin
                        req_q <= fetch_req(bus.inst_addr_i);
                        state <= I_BUSY;
                    end
                end
                D_BUSY, I_BUSY: begin
                    if (bus.m_ack_i || expired) begin
                        state     <= IDLE;
                        req_q     <= '0;
                        bus_err_q <= !bus.m_ack_i;
                        // An aborted read returns zero; a store never touches the read register.
                        if (state == I_BUSY) begin
                            inst_done_q <= 1'b1;
                            inst_data_q <= bus.m_ack_i ? bus.m_rdata_i : '0;
                        end else begin
                            data_done_q <= 1'b1;
                            if (req_q.we == WRITE_DISABLE) begin
                                data_rdata_q <= bus.m_ack_i ? bus.m_rdata_i : '0;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    req_q <= '0;
                end
            endcase
        end
    end

    assign bus.m_ce_o       = req_q.ce;
    assign bus.m_we_o       = req_q.we;
    assign bus.m_sel_o      = req_q.sel;
    assign bus.m_addr_o     = req_q.addr;
    assign bus.m_wdata_o    = req_q.wdata;
    assign bus.inst_data_o  = inst_data_q;
    assign bus.data_rdata_o = data_rdata_q;
    assign bus.inst_done_o  = inst_done_q;
    assign bus.data_done_o  = data_done_q;
    assign bus.bus_err_o    = bus_err_q;

    // Stalls release in the done cycle so the pipeline advances on the next edge.
    assign bus.stall_mem_o = bus.data_ce_i && !data_done_q;
    assign bus.stall_if_o  = bus.inst_ce_i && !inst_done_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a per-cycle vector table on a TIMEOUT=4
// instance plus hand sequences for the ack/timeout boundary on a TIMEOUT=2 instance.
module tb_mem_bus_arbiter;

    typedef struct packed {
        logic        rst;
        logic        inst_ce;
        logic [31:0] inst_addr;
        logic        data_ce;
        logic        data_we;
        logic [3:0]  data_sel;
        logic [31:0] data_addr;
        logic [31:0] data_wdata;
        logic        ack;
        logic [31:0] rdata;
    } stim_t;

    typedef struct packed {
        logic        ce;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] inst_data;
        logic [31:0] data_rdata;
        logic        inst_done;
        logic        data_done;
        logic        err;
        logic        stall_if;
        logic        stall_mem;
    } resp_t;

    typedef struct {
        string name;
        stim_t in;
        resp_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   num_applied    = 0;
    int   num_miscompares = 0;
    vec_t vecs[$];

    mem_bus_arbiter_if bif4 ();
    mem_bus_arbiter_if bif2 ();

    mem_bus_arbiter #(.TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif4)
    );

    mem_bus_arbiter #(.TIMEOUT(2)) dut_t2 (
        .clk (clk),
        .rst (rst),
        .bus (bif2)
    );

    always #5 clk = ~clk;

    function automatic stim_t st(input logic r, input logic ice, input logic [31:0] ia,
                                 input logic dce, input logic dwe, input logic [3:0] ds,
                                 input logic [31:0] da, input logic [31:0] dw,
                                 input logic a, input logic [31:0] rd);
        return '{r, ice, ia, dce, dwe, ds, da, dw, a, rd};
    endfunction

    function automatic resp_t rs(input logic ce, input logic we, input logic [3:0] sel,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] idata, input logic [31:0] drdata,
                                 input logic idone, input logic ddone, input logic err,
                                 input logic sif, input logic smem);
        return '{ce, we, sel, addr, wdata, idata, drdata, idone, ddone, err, sif, smem};
    endfunction

    function automatic resp_t get_resp(input int which);
        resp_t r;
        if (which == 0)
            r = '{bif4.m_ce_o, bif4.m_we_o, bif4.m_sel_o, bif4.m_addr_o, bif4.m_wdata_o,
                  bif4.inst_data_o, bif4.data_rdata_o, bif4.inst_done_o, bif4.data_done_o,
                  bif4.bus_err_o, bif4.stall_if_o, bif4.stall_mem_o};
        else
            r = '{bif2.m_ce_o, bif2.m_we_o, bif2.m_sel_o, bif2.m_addr_o, bif2.m_wdata_o,
                  bif2.inst_data_o, bif2.data_rdata_o, bif2.inst_done_o, bif2.data_done_o,
                  bif2.bus_err_o, bif2.stall_if_o, bif2.stall_mem_o};
        return r;
    endfunction

    function automatic void add_vec(input string n, input stim_t s, input resp_t r);
        vec_t v;
        v.name = n;
        v.in   = s;
        v.exp  = r;
        vecs.push_back(v);
    endfunction

    task automatic applyStimulus(input stim_t s);
        rst               = s.rst;
        bif4.inst_ce_i    = s.inst_ce;   bif2.inst_ce_i    = s.inst_ce;
        bif4.inst_addr_i  = s.inst_addr; bif2.inst_addr_i  = s.inst_addr;
        bif4.data_ce_i    = s.data_ce;   bif2.data_ce_i    = s.data_ce;
        bif4.data_we_i    = s.data_we;   bif2.data_we_i    = s.data_we;
        bif4.data_sel_i   = s.data_sel;  bif2.data_sel_i   = s.data_sel;
        bif4.data_addr_i  = s.data_addr; bif2.data_addr_i  = s.data_addr;
        bif4.data_wdata_i = s.data_wdata; bif2.data_wdata_i = s.data_wdata;
        bif4.m_ack_i      = s.ack;       bif2.m_ack_i      = s.ack;
        bif4.m_rdata_i    = s.rdata;     bif2.m_rdata_i    = s.rdata;
    endtask

    task automatic checkOutput(input string name, input int which, input resp_t exp);
        resp_t got;
        got = get_resp(which);
        num_applied++;
        if (got !== exp) begin
            num_miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] exp);
        num_applied++;
        if (got !== exp) begin
            num_miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        stim_t s;
        stim_t st_store;
        stim_t st_tload;

        st_store = st('0, '0, 32'h0, '1, '1, 4'b0100, 32'h104, 32'h5A5A5A5A, '0, 32'h0);
        st_tload = st('0, '0, 32'h0, '1, '0, 4'b0011, 32'h300, 32'h0, '0, 32'h0);

        // Store with ack in the third busy cycle, request held through done.
        add_vec("reset_state", st('1, '0, 32'h0, '0, '0, 4'h0, 32'h0, 32'h0, '0, 32'h0),
                rs('0, '0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0, '0, '0, '0, '0, '0));
        add_vec("st_req", st_store,
                rs('0, '0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0, '0, '0, '0, '0, '1));
        add_vec("st_busy1", st_store,
                rs('1, '1, 4'b0100, 32'h104, 32'h5A5A5A5A, 32'h0, 32'h0, '0, '0, '0, '0, '1));
        add_vec("st_busy2", st_store,
                rs('1, '1, 4'b0100, 32'h104, 32'h5A5A5A5A, 32'h0, 32'h0, '0, '0, '0, '0, '1));
        add_vec("st_busy3_ack", st('0, '0, 32'h0, '1, '1, 4'b0100, 32'h104, 32'h5A5A5A5A, '1, 32'hDEADBEEF),
                rs('1, '1, 4'b0100, 32'h104, 32'h5A5A5A5A, 32'h0, 32'h0, '0, '0, '0, '0, '1));
        add_vec("st_done", st_store,
                rs('0, '0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0, '0, '1, '0, '0, '0));
        add_vec("st_no_relaunch", st('0, '0, 32'h0, '0, '0, 4'h0, 32'h0, 32'h0, '0, 32'h0),
                rs('0, '0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0, '0, '0, '0, '0, '0));

        // Data and fetch arrive together; data wins, fetch follows two cycles later.
        add_vec("sim_reset", st('1, '0, 32'h0, '0, '0, 4'h0, 32'h0, 32'h0, '0, 32'h0),
                rs('0, '0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0, '0, '0, '0, '0, '0));
        add_vec("sim_req", st('0, '1, 32'h400, '1, '0, 4'hF, 32'h200, 32'h0, '0, 32'h0),
                rs('0, '0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0, '0, '0, '0, '1, '1));
        add_vec("sim_data_busy", st('0, '1, 32'h400, '1, '0, 4'hF, 32'h200, 32'h0, '1, 32'h11111111),
                rs('1, '0, 4'hF, 32'h200, 32'h0, 32'h0, 32'h0, '0, '0, '0, '1, '1));
        add_vec("sim_data_done", st('0, '1, 32'h400, '1, '0, 4'hF, 32'h200, 32'h0, '1, 32'h11111111),
                rs('0, '0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h11111111, '0, '1, '0, '1, '0));
        add_vec("sim_inst_busy", st('0, '1, 32'h400, '0, '0, 4'h0, 32'h0, 32'h0, '1, 32'h22222222),
                rs('1, '0, 4'hF, 32'h400, 32'h0, 32'h0, 32'h11111111, '0, '0, '0, '1, '0));
        add_vec("sim_inst_done", st('0, '1, 32'h400, '0, '0, 4'h0, 32'h0, 32'h0, '1, 32'h22222222),
                rs('0, '0, 4'h0, 32'h0, 32'h0, 32'h22222222, 32'h11111111, '1, '0, '0, '0, '0));
        add_vec("sim_idle", st('0, '0, 32'h0, '0, '0, 4'h0, 32'h0, 32'h0, '0, 32'h0),
                rs('0, '0, 4'h0, 32'h0, 32'h0, 32'h22222222, 32'h11111111, '0, '0, '0, '0, '0));

        // Load that never gets an ack: four waiting cycles, abort in the fifth.
        add_vec("to_req", st_tload,
                rs('0, '0, 4'h0, 32'h0, 32'h0, 32'h22222222, 32'h11111111, '0, '0, '0, '0, '1));
        for (int i = 1; i <= 5; i++)
            add_vec($sformatf("to_busy%0d", i), st_tload,
                    rs('1, '0, 4'b0011, 32'h300, 32'h0, 32'h22222222, 32'h11111111, '0, '0, '0, '0, '1));
        add_vec("to_done_err", st_tload,
                rs('0, '0, 4'h0, 32'h0, 32'h0, 32'h22222222, 32'h0, '0, '1, '1, '0, '0));
        add_vec("to_idle", st('0, '0, 32'h0, '0, '0, 4'h0, 32'h0, 32'h0, '0, 32'h0),
                rs('0, '0, 4'h0, 32'h0, 32'h0, 32'h22222222, 32'h0, '0, '0, '0, '0, '0));

        // Reset lands in the second busy cycle of a fetch; acks around it are dropped.
        add_vec("rf_req", st('0, '1, 32'h500, '0, '0, 4'h0, 32'h0, 32'h0, '0, 32'h0),
                rs('0, '0, 4'h0, 32'h0, 32'h0, 32'h22222222, 32'h0, '0, '0, '0, '1, '0));
        add_vec("rf_busy1", st('0, '1, 32'h500, '0, '0, 4'h0, 32'h0, 32'h0, '0, 32'h0),
                rs('1, '0, 4'hF, 32'h500, 32'h0, 32'h22222222, 32'h0, '0, '0, '0, '1, '0));
        add_vec("rf_busy2_rst", st('1, '0, 32'h0, '0, '0, 4'h0, 32'h0, 32'h0, '1, 32'h33333333),
                rs('1, '0, 4'hF, 32'h500, 32'h0, 32'h22222222, 32'h0, '0, '0, '0, '0, '0));
        add_vec("rf_after_rst", st('0, '0, 32'h0, '0, '0, 4'h0, 32'h0, 32'h0, '1, 32'h44444444),
                rs('0, '0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0, '0, '0, '0, '0, '0));
        add_vec("rf_ack_ignored", st('0, '0, 32'h0, '0, '0, 4'h0, 32'h0, 32'h0, '0, 32'h0),
                rs('0, '0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0, '0, '0, '0, '0, '0));

        applyStimulus(st('1, '0, 32'h0, '0, '0, 4'h0, 32'h0, 32'h0, '0, 32'h0));
        repeat (2) @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].in);
            @(negedge clk);
            checkOutput(vecs[i].name, 0, vecs[i].exp);
            next_cycle();
        end

        // TIMEOUT=2: ack arrives in the very cycle the counter hits the limit.
        s = st('1, '0, 32'h0, '0, '0, 4'h0, 32'h0, 32'h0, '0, 32'h0);
        applyStimulus(s);
        next_cycle();
        s.rst = 1'b0; s.data_ce = 1'b1; s.data_sel = 4'hF; s.data_addr = 32'h600;
        applyStimulus(s);
        next_cycle();
        next_cycle();
        next_cycle();
        s.ack = 1'b1; s.rdata = 32'h77777777;
        applyStimulus(s);
        @(negedge clk);
        checkValue("race_busy3_ce", 32'(bif2.m_ce_o), 32'h1);
        next_cycle();
        s.ack = 1'b0; s.rdata = 32'h0;
        applyStimulus(s);
        @(negedge clk);
        checkValue("race_done", 32'(bif2.data_done_o), 32'h1);
        checkValue("race_no_err", 32'(bif2.bus_err_o), 32'h0);
        checkValue("race_rdata", bif2.data_rdata_o, 32'h77777777);
        next_cycle();
        s.data_ce = 1'b0;
        applyStimulus(s);
        next_cycle();

        // Same shape without the ack: TIMEOUT=2 aborts, TIMEOUT=4 keeps waiting.
        s.data_ce = 1'b1; s.data_addr = 32'h700;
        applyStimulus(s);
        next_cycle();
        next_cycle();
        next_cycle();
        @(negedge clk);
        checkValue("bnd_busy3_ce", 32'(bif2.m_ce_o), 32'h1);
        next_cycle();
        @(negedge clk);
        checkValue("bnd_t2_done", 32'(bif2.data_done_o), 32'h1);
        checkValue("bnd_t2_err", 32'(bif2.bus_err_o), 32'h1);
        checkValue("bnd_t2_rdata", bif2.data_rdata_o, 32'h0);
        checkValue("bnd_t4_still_busy", 32'(bif4.m_ce_o), 32'h1);
        checkValue("bnd_t4_no_err", 32'(bif4.bus_err_o), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", num_applied, num_miscompares);
        $finish;
    end

endmodule
